// File: rtl/spi_master.sv
// Byte-wide SPI mode-0 master: shifts one command byte out MSB first on MOSI while
// capturing MISO, and registers the software-owned chip-select level onto cs_n.
module spi_master #(
  parameter int HALF_PERIOD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_trigger,
  input  logic [7:0] spi_command,
  input  logic       spi_cs_level,
  output logic       spi_busy,
  output logic [7:0] spi_response,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(HALF_PERIOD - 1);

  state_t     state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] half_reg, half_next;
  logic [7:0] resp_reg, resp_next;
  logic [2:0] bit_reg, bit_next;
  logic       sck_reg, sck_next;
  logic       mosi_reg, mosi_next;
  logic       busy_reg, busy_next;
  logic       cs_n_reg;
  logic       half_done;

  assign half_done = (half_reg == HALF_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shift_reg <= 8'h00;
      half_reg  <= 8'h00;
      resp_reg  <= 8'h00;
      bit_reg   <= 3'd0;
      sck_reg   <= 1'b0;
      mosi_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      half_reg  <= half_next;
      resp_reg  <= resp_next;
      bit_reg   <= bit_next;
      sck_reg   <= sck_next;
      mosi_reg  <= mosi_next;
      busy_reg  <= busy_next;
    end
  end

  // Chip select is a plain register, deliberately decoupled from the shift engine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_reg <= 1'b1;
    end else begin
      cs_n_reg <= spi_cs_level;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    half_next  = half_reg;
    resp_next  = resp_reg;
    bit_next   = bit_reg;
    sck_next   = sck_reg;
    mosi_next  = mosi_reg;
    busy_next  = busy_reg;

    case (state_reg)
      IDLE: begin
        if (spi_trigger) begin
          shift_next = spi_command;
          mosi_next  = spi_command[7];
          bit_next   = 3'd0;
          half_next  = 8'h00;
          busy_next  = 1'b1;
          state_next = LOW;
        end
      end

      LOW: begin
        if (half_done) begin
          half_next  = 8'h00;
          sck_next   = 1'b1;
          state_next = HIGH;
        end else begin
          half_next = half_reg + 8'h01;
        end
      end

      HIGH: begin
        if (half_done) begin
          // MISO is sampled on the same edge that drops SCK; the next MOSI bit is the
          // pre-shift bit 6, which becomes the new MSB.
          half_next  = 8'h00;
          shift_next = {shift_reg[6:0], miso};
          sck_next   = 1'b0;
          if (bit_reg != 3'd7) begin
            bit_next   = bit_reg + 3'd1;
            mosi_next  = shift_reg[6];
            state_next = LOW;
          end else begin
            resp_next  = {shift_reg[6:0], miso};
            busy_next  = 1'b0;
            state_next = IDLE;
          end
        end else begin
          half_next = half_reg + 8'h01;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign spi_busy     = busy_reg;
  assign spi_response = resp_reg;
  assign sck          = sck_reg;
  assign mosi         = mosi_reg;
  assign cs_n         = cs_n_reg;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (HALF_PERIOD 2 and 1) checked against a
// byte-level model of what a mode-0 transfer must put on the wire and return.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       trig, csl, mode, sel;
  logic [7:0] cmd, slave_byte;

  logic       trig_a, trig_b;
  logic       busy_a, busy_b, sck_a, sck_b, mosi_a, mosi_b;
  logic       miso_a, miso_b, cs_n_a, cs_n_b;
  logic [7:0] resp_a, resp_b;

  logic       busy_s, sck_s, mosi_s, cs_n_s;
  logic [7:0] resp_s;

  int checks = 0;
  int errors = 0;

  int rises = 0, falls = 0, sck_falls = 0;
  int rise_base, fall_base, slave_base, bit_base;
  logic bits_log[$];
  logic [7:0] last_resp [2];

  int         slave_k;
  logic [7:0] slave_shift;
  logic       slave_bit;

  assign trig_a = trig & ~sel;
  assign trig_b = trig & sel;

  // Slave presents its MSB first and advances one bit on every SCK fall.
  assign slave_k     = sck_falls - slave_base;
  assign slave_shift = slave_byte << slave_k;
  assign slave_bit   = slave_shift[7];
  assign miso_a      = mode ? slave_bit : mosi_a;
  assign miso_b      = mode ? slave_bit : mosi_b;

  assign busy_s = sel ? busy_b : busy_a;
  assign sck_s  = sel ? sck_b  : sck_a;
  assign mosi_s = sel ? mosi_b : mosi_a;
  assign cs_n_s = sel ? cs_n_b : cs_n_a;
  assign resp_s = sel ? resp_b : resp_a;

  spi_master #(.HALF_PERIOD(2)) u_hp2 (
    .clk(clk), .rst_n(rst_n), .spi_trigger(trig_a), .spi_command(cmd),
    .spi_cs_level(csl), .spi_busy(busy_a), .spi_response(resp_a),
    .sck(sck_a), .mosi(mosi_a), .miso(miso_a), .cs_n(cs_n_a)
  );

  spi_master #(.HALF_PERIOD(1)) u_hp1 (
    .clk(clk), .rst_n(rst_n), .spi_trigger(trig_b), .spi_command(cmd),
    .spi_cs_level(csl), .spi_busy(busy_b), .spi_response(resp_b),
    .sck(sck_b), .mosi(mosi_b), .miso(miso_b), .cs_n(cs_n_b)
  );

  always @(posedge sck_s) begin
    rises <= rises + 1;
    bits_log.push_back(mosi_s);
  end
  always @(negedge sck_s) sck_falls <= sck_falls + 1;
  always @(negedge busy_s) falls <= falls + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_resp(input logic m, input logic [7:0] c,
                                            input logic [7:0] sb);
    return m ? sb : c;
  endfunction

  task automatic start(input logic s, input logic m, input logic [7:0] c,
                       input logic [7:0] sb);
    sel        = s;
    mode       = m;
    slave_byte = sb;
    slave_base = sck_falls;
    rise_base  = rises;
    fall_base  = falls;
    bit_base   = bits_log.size();
    cmd        = c;
    trig       = 1'b1;
    @(posedge clk);
    #1;
    trig = 1'b0;
    check("busy_start", int'(busy_s), 1);
    check("mosi_msb", int'(mosi_s), int'(c[7]));
  endtask

  task automatic finish_xfer(input int hp, input logic [7:0] c, input logic [7:0] exp_resp,
                             input logic [7:0] prev_resp, input bit collide);
    int n;
    bit done;
    logic [7:0] mb;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 3) check("resp_hold", int'(resp_s), int'(prev_resp));
      if (!busy_s) begin
        done = 1'b1;
      end else if (n > 16 * hp + 8) begin
        check("busy_timeout", n, 16 * hp);
        done = 1'b1;
      end else if (collide) begin
        trig = (n == 5) || (n == 16 * hp - 1);
        if (trig) cmd = 8'h22;
      end
    end
    mb = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (bit_base + i < bits_log.size()) mb[7-i] = bits_log[bit_base+i];
    end
    $display("xfer hp=%0d cmd=0x%02h resp=0x%02h busy_cycles=%0d", hp, c, resp_s, n);
    check("busy_cycles", n, 16 * hp);
    check("resp", int'(resp_s), int'(exp_resp));
    check("sck_pulses", rises - rise_base, 8);
    check("busy_falls", falls - fall_base, 1);
    check("mosi_bits", int'(mb), int'(c));
    check("sck_idle", int'(sck_s), 0);
  endtask

  initial begin
    trig = 1'b0; csl = 1'b1; mode = 1'b0; sel = 1'b0;
    cmd = 8'h00; slave_byte = 8'h00;
    last_resp[0] = 8'h00;
    last_resp[1] = 8'h00;

    // Reset held with random activity on every input.
    for (int i = 0; i < 6; i++) begin
      trig = 1'($urandom_range(0, 1));
      cmd  = 8'($urandom);
      csl  = 1'($urandom_range(0, 1));
      mode = 1'($urandom_range(0, 1));
      sel  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("rst_sck", int'(sck_s), 0);
      check("rst_mosi", int'(mosi_s), 0);
      check("rst_busy", int'(busy_s), 0);
      check("rst_resp", int'(resp_s), 0);
      check("rst_cs_n", int'(cs_n_s), 1);
    end
    trig = 1'b0; sel = 1'b0; csl = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Loopback 0xA5.
    start(1'b0, 1'b0, 8'hA5, 8'h00);
    finish_xfer(2, 8'hA5, model_resp(1'b0, 8'hA5, 8'h00), last_resp[0], 1'b0);
    last_resp[0] = 8'hA5;

    // Slave returns 0x3C while master sends 0xC3.
    start(1'b0, 1'b1, 8'hC3, 8'h3C);
    finish_xfer(2, 8'hC3, model_resp(1'b1, 8'hC3, 8'h3C), last_resp[0], 1'b0);
    last_resp[0] = 8'h3C;

    // Triggers during the transfer and at the completion edge are dropped.
    start(1'b0, 1'b0, 8'h11, 8'h00);
    finish_xfer(2, 8'h11, 8'h11, last_resp[0], 1'b1);
    last_resp[0] = 8'h11;
    start(1'b0, 1'b0, 8'h22, 8'h00);
    finish_xfer(2, 8'h22, 8'h22, last_resp[0], 1'b0);
    last_resp[0] = 8'h22;

    // Asynchronous reset after three SCK pulses of 0xFF.
    start(1'b0, 1'b0, 8'hFF, 8'h00);
    begin
      int w;
      w = 0;
      while (rises - rise_base < 3 && w < 200) begin
        @(posedge clk);
        #1;
        w++;
      end
      check("pulses_before_rst", rises - rise_base, 3);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sck", int'(sck_s), 0);
    check("mid_rst_mosi", int'(mosi_s), 0);
    check("mid_rst_busy", int'(busy_s), 0);
    check("mid_rst_resp", int'(resp_s), 0);
    check("mid_rst_cs_n", int'(cs_n_s), 1);
    last_resp[0] = 8'h00;
    last_resp[1] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start(1'b0, 1'b0, 8'h81, 8'h00);
    finish_xfer(2, 8'h81, 8'h81, last_resp[0], 1'b0);
    last_resp[0] = 8'h81;

    // Chip-select path and HALF_PERIOD=1 instance.
    sel = 1'b1;
    csl = 1'b1;
    @(posedge clk);
    #1;
    check("cs_n_high", int'(cs_n_s), 1);
    csl = 1'b0;
    #1;
    check("cs_n_not_yet", int'(cs_n_s), 1);
    @(posedge clk);
    #1;
    check("cs_n_low", int'(cs_n_s), 0);
    csl = 1'b1;
    @(posedge clk);
    #1;
    check("cs_n_back", int'(cs_n_s), 1);
    start(1'b1, 1'b0, 8'h5A, 8'h00);
    finish_xfer(1, 8'h5A, 8'h5A, last_resp[1], 1'b0);
    last_resp[1] = 8'h5A;

    // Randomized transfers on both instances, loopback or slave-driven MISO.
    for (int i = 0; i < 8; i++) begin
      logic s, m;
      logic [7:0] c, sb, er;
      int hp, idx;
      s   = 1'($urandom_range(0, 1));
      m   = 1'($urandom_range(0, 1));
      c   = 8'($urandom);
      sb  = 8'($urandom);
      hp  = s ? 1 : 2;
      idx = s ? 1 : 0;
      er  = model_resp(m, c, sb);
      csl = 1'($urandom_range(0, 1));
      start(s, m, c, sb);
      finish_xfer(hp, c, er, last_resp[idx], 1'b0);
      last_resp[idx] = er;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
